// File: rtl/counter_bank_mod.sv
// Bank of CH independent W-bit up/down counters with load, clear, programmable
// terminal value, wrap/saturate behaviour and an optional cascade enable chain.

module counter_lane #(
    parameter int W        = 4,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic         up_dn,
    input  logic         sclr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] q,
    output logic         at,
    output logic         wrap
);
    localparam logic [W-1:0] ONE = W'(1);

    // Boundary depends only on state and direction, so the cascade enable never loops back.
    assign at = up_dn ? (q == tc_val) : (q == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (sclr) begin
                q <= '0;
            end else if (load) begin
                q <= load_val;
            end else if (en && !at) begin
                q <= up_dn ? q + ONE : q - ONE;
            end else if (en && at && (SATURATE == 0)) begin
                q    <= up_dn ? '0 : tc_val;
                wrap <= 1'b1;
            end
        end
    end
endmodule

module counter_bank_mod #(
    parameter int W        = 4,
    parameter int CH       = 2,
    parameter int SATURATE = 0,
    parameter int CASCADE  = 0
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [CH-1:0]   count_en,
    input  logic [CH-1:0]   up_dn,
    input  logic [CH-1:0]   sclr,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] load_val,
    input  logic [CH*W-1:0] tc_val,
    output logic [CH*W-1:0] q,
    output logic [CH-1:0]   tc,
    output logic [CH-1:0]   wrap
);
    logic [CH-1:0] at;
    logic [CH-1:0] en;

    // Ripple the enable through a local carry so the whole chain settles in one cycle.
    always_comb begin
        logic carry;
        carry = 1'b1;
        en    = '0;
        tc    = '0;
        for (int i = 0; i < CH; i++) begin
            en[i] = count_en[i] & ((CASCADE == 0 || i == 0) ? 1'b1 : carry);
            tc[i] = en[i] & at[i];
            carry = tc[i];
        end
    end

    counter_lane #(.W(W), .SATURATE(SATURATE)) u_lane [CH-1:0] (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (en),
        .up_dn    (up_dn),
        .sclr     (sclr),
        .load     (load),
        .load_val (load_val),
        .tc_val   (tc_val),
        .q        (q),
        .at       (at),
        .wrap     (wrap)
    );
endmodule

// File: tb/tb_counter_bank_mod.sv
// Drives three counter banks (wrap, saturate, cascade) from shared inputs and
// scores q/wrap against a cycle model through an expected-value queue.

module tb_counter_bank_mod;
    localparam int W  = 4;
    localparam int CH = 2;
    localparam int M  = 1 << W;

    typedef struct {
        int d;
        int ch;
        int q;
        int w;
    } exp_t;

    logic            clk = 1'b0;
    logic            clr_n;
    logic [CH-1:0]   count_en, up_dn, sclr, load;
    logic [CH*W-1:0] load_val, tc_val;
    logic [CH*W-1:0] q_d [3];
    logic [CH-1:0]   tc_d [3];
    logic [CH-1:0]   wrap_d [3];

    exp_t sbq[$];
    int   mq [3][CH];
    int   mw [3][CH];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    counter_bank_mod #(.W(W), .CH(CH), .SATURATE(0), .CASCADE(0)) dut_wrap (
        .clk(clk), .clr_n(clr_n), .count_en(count_en), .up_dn(up_dn), .sclr(sclr),
        .load(load), .load_val(load_val), .tc_val(tc_val),
        .q(q_d[0]), .tc(tc_d[0]), .wrap(wrap_d[0]));

    counter_bank_mod #(.W(W), .CH(CH), .SATURATE(1), .CASCADE(0)) dut_sat (
        .clk(clk), .clr_n(clr_n), .count_en(count_en), .up_dn(up_dn), .sclr(sclr),
        .load(load), .load_val(load_val), .tc_val(tc_val),
        .q(q_d[1]), .tc(tc_d[1]), .wrap(wrap_d[1]));

    counter_bank_mod #(.W(W), .CH(CH), .SATURATE(0), .CASCADE(1)) dut_cas (
        .clk(clk), .clr_n(clr_n), .count_en(count_en), .up_dn(up_dn), .sclr(sclr),
        .load(load), .load_val(load_val), .tc_val(tc_val),
        .q(q_d[2]), .tc(tc_d[2]), .wrap(wrap_d[2]));

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qv(input int d, input int ch);
        return int'(q_d[d][ch*W +: W]);
    endfunction

    // One clock: predict tc now and q/wrap after the edge, then score the DUTs.
    task automatic step();
        int   nq [3][CH];
        int   nw [3][CH];
        int   tcv, lv, en, at, carry;
        exp_t e;
        #1;
        for (int d = 0; d < 3; d++) begin
            carry = 1;
            for (int c = 0; c < CH; c++) begin
                tcv = int'(tc_val[c*W +: W]);
                lv  = int'(load_val[c*W +: W]);
                en  = int'(count_en[c]);
                if (d == 2 && c > 0) en = en & carry;
                at  = up_dn[c] ? int'(mq[d][c] == tcv) : int'(mq[d][c] == 0);
                carry = en & at;
                check($sformatf("tc d%0d c%0d", d, c), int'(tc_d[d][c]), carry);
                nq[d][c] = mq[d][c];
                nw[d][c] = 0;
                if (sclr[c])                     nq[d][c] = 0;
                else if (load[c])                nq[d][c] = lv;
                else if (en == 1 && at == 0)     nq[d][c] = up_dn[c] ? (mq[d][c] + 1) % M : (mq[d][c] + M - 1) % M;
                else if (en == 1 && d != 1) begin
                    nq[d][c] = up_dn[c] ? 0 : tcv;
                    nw[d][c] = 1;
                end
                sbq.push_back('{d: d, ch: c, q: nq[d][c], w: nw[d][c]});
            end
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("q d%0d c%0d", e.d, e.ch), qv(e.d, e.ch), e.q);
            check($sformatf("wrap d%0d c%0d", e.d, e.ch), int'(wrap_d[e.d][e.ch]), e.w);
        end
        mq = nq;
        mw = nw;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_all();
        sclr = '1; load = '0;
        step();
        sclr = '0;
    endtask

    initial begin
        clr_n = 1'b0; count_en = '0; up_dn = '0; sclr = '0; load = '0;
        load_val = '0; tc_val = '0;
        #7;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset q d%0d", d), int'(q_d[d]), 0);
            check($sformatf("reset wrap d%0d", d), int'(wrap_d[d]), 0);
            check($sformatf("reset tc d%0d", d), int'(tc_d[d]), 0);
        end
        clr_n = 1'b1;
        foreach (mq[d, c]) begin mq[d][c] = 0; mw[d][c] = 0; end

        // Full-range count up with tc_val=15
        tc_val = {4'd15, 4'd15}; up_dn = '1; count_en = '1;
        clear_all();
        steps(20);
        check("t1 wrap q0", qv(0, 0), 4);
        check("t1 sat q0", qv(1, 0), 15);
        check("t1 cas q1", qv(2, 1), 1);

        // Decade counter on channel 0
        tc_val = {4'd15, 4'd9};
        clear_all();
        steps(9);
        check("t2 tc at 9", int'(tc_d[0][0]), 1);
        step();
        check("t2 q0 wrapped", qv(0, 0), 0);
        check("t2 wrap pulse", int'(wrap_d[0][0]), 1);
        steps(2);

        // Load then count down through zero
        up_dn = '0; tc_val = {4'd5, 4'd5}; load_val = {4'd2, 4'd2}; load = '1;
        step();
        load = '0;
        check("t3 loaded", qv(0, 0), 2);
        steps(4);
        check("t3 q after down", qv(0, 0), 4);
        check("t3 sat held 0", qv(1, 0), 0);

        // Saturate at tc_val=7
        up_dn = '1; tc_val = {4'd7, 4'd7};
        clear_all();
        steps(12);
        check("t4 sat q", qv(1, 0), 7);
        check("t4 sat tc", int'(tc_d[1][0]), 1);
        check("t4 sat wrap", int'(wrap_d[1][0]), 0);

        // Cascaded 8-bit chain
        tc_val = {4'd15, 4'd15};
        clear_all();
        steps(40);
        check("t5 cas q0", qv(2, 0), 8);
        check("t5 cas q1", qv(2, 1), 2);

        // tc_val=0 counting up, and counting up from above tc_val
        tc_val = '0;
        clear_all();
        steps(3);
        load_val = {4'd12, 4'd12}; tc_val = {4'd5, 4'd5}; load = '1;
        step();
        load = '0;
        steps(8);

        // sclr beats load beats count; then async reset mid-count
        sclr = '1; load = '1; load_val = {4'd9, 4'd9};
        step();
        sclr = '0; load = '0;
        check("t6 sclr prio", int'(q_d[0]), 0);
        steps(3);
        clr_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async q d%0d", d), int'(q_d[d]), 0);
            check($sformatf("async wrap d%0d", d), int'(wrap_d[d]), 0);
        end
        foreach (mq[d, c]) begin mq[d][c] = 0; mw[d][c] = 0; end
        #1 clr_n = 1'b1;
        steps(2);

        // Random mix
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < CH; c++) begin
                count_en[c] = ($urandom_range(0, 3) != 0);
                up_dn[c]    = $urandom_range(0, 1);
                sclr[c]     = ($urandom_range(0, 15) == 0);
                load[c]     = ($urandom_range(0, 11) == 0);
            end
            load_val = CH*W'($urandom);
            tc_val   = CH*W'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
